// File: rtl/ofm_pkg.sv
// Shared types and helpers for the output feature-map writeback engine.
package ofm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEF_OUT_SIZE    = 28;
  localparam int DEF_OUT_CHANNEL = 6;
  localparam int FRAME_LEN       = DEF_OUT_CHANNEL * DEF_OUT_SIZE * DEF_OUT_SIZE;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic longint sat_clamp(input longint v, input int w);
    longint hi;
    longint lo;
    longint res;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -hi - 1;
    res = v;
    if (v > hi) res = hi;
    else if (v < lo) res = lo;
    return res;
  endfunction

endpackage

// File: rtl/ofm_writer_if.sv
// Accumulator-side handshake and output buffer port of the writeback engine.
interface ofm_writer_if #(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic                     start;
  logic                     acc_valid;
  logic signed [ACC_W-1:0]  acc_data;
  logic                     acc_ready;
  logic                     out_ena;
  logic                     out_wea;
  logic [ADDR_W-1:0]        out_addr;
  logic signed [DATA_W-1:0] out_data;
  logic                     busy;
  logic                     done;

  modport master (
    output start, acc_valid, acc_data,
    input  acc_ready, out_ena, out_wea, out_addr, out_data, busy, done
  );

  modport slave (
    input  start, acc_valid, acc_data,
    output acc_ready, out_ena, out_wea, out_addr, out_data, busy, done
  );
endinterface

// File: rtl/ofm_quant.sv
// Combinational quantizer: floor shift, optional ReLU, saturate to DATA_W.
module ofm_quant
  import ofm_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 8,
  parameter int SHIFT  = 8,
  parameter int RELU   = 1
) (
  input  logic signed [ACC_W-1:0]  acc_data,
  output logic signed [DATA_W-1:0] q_data
);

  logic signed [ACC_W-1:0] shifted;
  longint                  wide;

  always_comb begin
    shifted = acc_data >>> SHIFT;
    wide    = longint'(shifted);
    if (RELU != 0 && wide < 0) wide = '0;
    q_data  = DATA_W'(sat_clamp(wide, DATA_W));
  end

endmodule

// File: rtl/ofm_writer.sv
// Writeback engine: accepts accumulator results, quantizes them and writes
// them to the output buffer in raster order through a two-stage pipeline.
module ofm_writer
  import ofm_pkg::*;
#(
  parameter int ACC_W       = 32,
  parameter int DATA_W      = 8,
  parameter int OUT_SIZE    = DEF_OUT_SIZE,
  parameter int OUT_CHANNEL = DEF_OUT_CHANNEL,
  parameter int ADDR_W      = 16,
  parameter int SHIFT       = 8,
  parameter int RELU        = 1
) (
  input logic         clock,
  input logic         rst_n,
  ofm_writer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(OUT_CHANNEL - 1);
  localparam logic [ADDR_W-1:0] SIZE_A   = ADDR_W'(OUT_SIZE);
  localparam logic [ADDR_W-1:0] PLANE_A  = ADDR_W'(OUT_SIZE * OUT_SIZE);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  if (longint'(OUT_CHANNEL) * OUT_SIZE * OUT_SIZE > (longint'(1) << ADDR_W)) begin : g_addr_chk
    $error("ofm_writer: OUT_CHANNEL*OUT_SIZE^2 does not fit in ADDR_W address bits");
  end

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        c_q, c_d, r_q, r_d, m_q, m_d;
  logic                     acc_ready_q, acc_ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [ADDR_W-1:0]        s1_addr_q, s1_addr_d;
  logic signed [DATA_W-1:0] s1_data_q, s1_data_d;
  logic                     out_wea_q, out_wea_d, out_last_q, out_last_d;
  logic [ADDR_W-1:0]        out_addr_q, out_addr_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     accept;
  logic                     last_pos;
  logic signed [DATA_W-1:0] q_data;

  ofm_quant #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_quant (
    .acc_data(bus.acc_data),
    .q_data  (q_data)
  );

  assign accept   = bus.acc_valid && acc_ready_q;
  assign last_pos = (m_q == LAST_CH) && (r_q == LAST_POS) && (c_q == LAST_POS);

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    r_d        = r_q;
    m_d        = m_q;
    done_d     = 1'b0;
    s1_vld_d   = accept;
    s1_last_d  = accept && last_pos;
    s1_addr_d  = accept ? (m_q * PLANE_A + r_q * SIZE_A + c_q) : s1_addr_q;
    s1_data_d  = accept ? q_data : s1_data_q;
    out_wea_d  = s1_vld_q;
    out_last_d = s1_last_q;
    out_addr_d = s1_vld_q ? s1_addr_q : out_addr_q;
    out_data_d = s1_vld_q ? s1_data_q : out_data_q;

    case (state_q)
      IDLE: begin
        // The cycle that reports done still looks idle; start is only honoured after it.
        if (bus.start && !done_q) begin
          state_d = RUN;
          c_d     = '0;
          r_d     = '0;
          m_d     = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (c_q == LAST_POS) begin
            c_d = '0;
            if (r_q == LAST_POS) begin
              r_d = '0;
              m_d = last_pos ? '0 : m_q + ONE_A;
            end else begin
              r_d = r_q + ONE_A;
            end
          end else begin
            c_d = c_q + ONE_A;
          end
          if (last_pos) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    acc_ready_d = (state_d == RUN);
    busy_d      = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge rst_n) begin
    // NOTE: pipeline data registers are reset too, so the buffer port reads zero after reset.
    if (!rst_n) begin
      state_q     <= IDLE;
      c_q         <= '0;
      r_q         <= '0;
      m_q         <= '0;
      acc_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      out_wea_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      r_q         <= r_d;
      m_q         <= m_d;
      acc_ready_q <= acc_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_addr_q   <= s1_addr_d;
      s1_data_q   <= s1_data_d;
      out_wea_q   <= out_wea_d;
      out_last_q  <= out_last_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.acc_ready = acc_ready_q;
  assign bus.out_ena   = out_wea_q;
  assign bus.out_wea   = out_wea_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ofm_writer.sv
// Randomized bench for ofm_writer: a frame-level reference model predicts every
// buffer write, ready/busy/done, for a RELU=1 and a RELU=0 instance in parallel.
module tb_ofm_writer;

  localparam int FRAME = 6 * 28 * 28;

  typedef struct {
    longint due;
    int     addr;
    int     q_relu;
    int     q_norelu;
  } wr_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  ofm_writer_if #(.ACC_W(32), .DATA_W(8), .ADDR_W(16)) bus ();
  ofm_writer_if #(.ACC_W(32), .DATA_W(8), .ADDR_W(16)) bus_nr ();

  assign bus_nr.start     = bus.start;
  assign bus_nr.acc_valid = bus.acc_valid;
  assign bus_nr.acc_data  = bus.acc_data;

  ofm_writer #(.RELU(1)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  ofm_writer #(.RELU(0)) dut_nr (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus_nr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Quantization straight from the arithmetic rules: floor divide by 256, ReLU, clamp.
  function automatic int quant(input int acc, input bit relu);
    int q;
    q = acc >>> 8;
    if (relu && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic int rand_acc();
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom);
      1:       v = int'($urandom_range(0, 70000)) - 35000;
      2:       v = int'($urandom_range(0, 2000)) - 1000;
      default: v = int'($urandom_range(0, 600000)) - 300000;
    endcase
    return v;
  endfunction

  // Reference model state: the block is "running" while accepting, and the
  // frame ends three cycles after its last accept (two pipeline cycles + done).
  bit     running = 1'b0;
  longint done_at = -1;
  longint cyc     = 0;
  int     m_n     = 0;
  wr_t    pend[$];
  wr_t    w;

  int     vals[FRAME];
  int     wr_total = 0, done_total = 0;
  int     frame_wr = 0, frame_done = 0, gap_cnt = 0, cyc_gap = 0;
  int     first_addr = -1, last_addr = -1;
  longint last_wr_cyc = -1, done_cyc = -1;
  int     wr_main[FRAME];
  int     wr_nr[FRAME];
  bit     wrote[FRAME];

  always @(negedge clock) begin
    if (!rst_n) begin
      running = 1'b0;
      done_at = -1;
      pend.delete();
      m_n     = 0;
    end else begin : cmp
      bit exp_wr;
      bit exp_busy;
      bit exp_done;
      exp_busy = running || (done_at > cyc);
      exp_done = (cyc == done_at);
      exp_wr   = (pend.size() > 0) && (pend[0].due == cyc);
      check("acc_ready", bus.acc_ready, running);
      check("acc_ready_norelu", bus_nr.acc_ready, running);
      check("busy", bus.busy, exp_busy);
      check("busy_norelu", bus_nr.busy, exp_busy);
      check("done", bus.done, exp_done);
      check("done_norelu", bus_nr.done, exp_done);
      check("out_wea", bus.out_wea, exp_wr);
      check("out_ena", bus.out_ena, exp_wr);
      check("out_wea_norelu", bus_nr.out_wea, exp_wr);
      if (exp_wr) begin
        w = pend.pop_front();
        check("out_addr", bus.out_addr, w.addr);
        check("out_data", bus.out_data, w.q_relu);
        check("out_addr_norelu", bus_nr.out_addr, w.addr);
        check("out_data_norelu", bus_nr.out_data, w.q_norelu);
      end

      if (bus.out_wea === 1'b1) begin
        wr_total++;
        frame_wr++;
        if (first_addr < 0) first_addr = int'(bus.out_addr);
        else begin
          if (int'(bus.out_addr) != last_addr + 1) gap_cnt++;
          if (last_wr_cyc != cyc - 1) cyc_gap++;
        end
        last_addr   = int'(bus.out_addr);
        last_wr_cyc = cyc;
        if (int'(bus.out_addr) < FRAME) begin
          wr_main[bus.out_addr] = int'(bus.out_data);
          wr_nr[bus.out_addr]   = int'(bus_nr.out_data);
          wrote[bus.out_addr]   = 1'b1;
        end
      end
      if (bus.done === 1'b1) begin
        done_total++;
        frame_done++;
        done_cyc = cyc;
      end

      if (bus.start && !running && done_at < cyc) begin
        running    = 1'b1;
        m_n        = 0;
        frame_wr   = 0;
        frame_done = 0;
        gap_cnt    = 0;
        cyc_gap    = 0;
        first_addr = -1;
        foreach (wrote[i]) wrote[i] = 1'b0;
      end else if (running && bus.acc_valid) begin
        w.due      = cyc + 2;
        w.addr     = m_n;
        w.q_relu   = quant(int'(bus.acc_data), 1'b1);
        w.q_norelu = quant(int'(bus.acc_data), 1'b0);
        pend.push_back(w);
        m_n++;
        if (m_n == FRAME) begin
          running = 1'b0;
          done_at = cyc + 3;
        end
      end
    end
    cyc++;
  end

  task automatic fill_random();
    foreach (vals[i]) vals[i] = rand_acc();
  endtask

  // mode 0: acc_valid held high, 1: toggling 1,0, 2: random ~70% duty.
  task automatic run_frame(input int mode, input bit mid_start);
    int  d0;
    bit  pulsed;
    d0     = done_total;
    pulsed = 1'b0;
    @(posedge clock);
    #1;
    bus.start     = 1'b1;
    bus.acc_valid = 1'b0;
    bus.acc_data  = vals[0];
    for (int t = 0; t < 20000 && done_total == d0; t++) begin
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      if (mid_start && !pulsed && m_n >= 500) begin
        bus.start = 1'b1;
        pulsed    = 1'b1;
      end
      case (mode)
        0:       bus.acc_valid = 1'b1;
        1:       bus.acc_valid = (t % 2 == 0);
        default: bus.acc_valid = ($urandom_range(0, 9) < 7);
      endcase
      bus.acc_data = vals[(m_n < FRAME) ? m_n : 0];
    end
    bus.start     = 1'b0;
    bus.acc_valid = 1'b0;
    check("frame_done_within_budget", done_total != d0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc_ready"}, bus.acc_ready, 0);
    check({tag, "_out_ena"}, bus.out_ena, 0);
    check({tag, "_out_wea"}, bus.out_wea, 0);
    check({tag, "_out_addr"}, bus.out_addr, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.acc_valid = 1'b0;
    bus.acc_data  = '0;
    repeat (3) @(posedge clock);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // acc_valid while idle must be ignored.
    @(posedge clock);
    #1;
    bus.acc_valid = 1'b1;
    bus.acc_data  = 32'sd5000;
    repeat (6) @(posedge clock);
    #1;
    check("idle_valid_no_write", wr_total, 0);
    check("idle_valid_no_ready", bus.acc_ready, 0);
    bus.acc_valid = 1'b0;

    // Frame 1: held valid, directed values at known positions, stray start mid-frame.
    fill_random();
    vals[0]   = 4660;
    vals[1]   = 40000;
    vals[2]   = -300;
    vals[28]  = -40000;
    vals[784] = 25600;
    run_frame(0, 1'b1);
    check("f1_write_count", frame_wr, FRAME);
    check("f1_first_addr", first_addr, 0);
    check("f1_last_addr", last_addr, FRAME - 1);
    check("f1_addr_gaps", gap_cnt, 0);
    check("f1_cycle_gaps", cyc_gap, 0);
    check("f1_done_count", frame_done, 1);
    check("f1_done_after_last_write", done_cyc - last_wr_cyc, 1);
    check("q_4660", wr_main[0], 18);
    check("q_40000_sat", wr_main[1], 127);
    check("q_m300_relu", wr_main[2], 0);
    check("q_m300_norelu", wr_nr[2], -2);
    check("row_wrap_written", wrote[28], 1);
    check("row_wrap_data_norelu", wr_nr[28], -128);
    check("chan_wrap_written", wrote[784], 1);
    check("chan_wrap_data", wr_main[784], 100);
    repeat (3) @(posedge clock);

    // Frame 2: throttled input.
    fill_random();
    run_frame(1, 1'b0);
    check("f2_write_count", frame_wr, FRAME);
    check("f2_addr_gaps", gap_cnt, 0);
    check("f2_done_count", frame_done, 1);

    // Frame 3: reset after 100 accepts.
    fill_random();
    @(posedge clock);
    #1;
    bus.start = 1'b1;
    for (int t = 0; t < 2000 && m_n < 100; t++) begin
      @(posedge clock);
      #1;
      bus.start     = 1'b0;
      bus.acc_valid = ($urandom_range(0, 9) < 7);
      bus.acc_data  = vals[m_n];
    end
    check("reached_100_accepts", m_n >= 100, 1);
    @(posedge clock);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_frame_reset");
    bus.acc_valid = 1'b0;
    @(posedge clock);
    #2;
    check_reset_outputs("held_reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clock);
    check("post_reset_no_write", bus.out_wea, 0);

    // Frame 4: restart after reset must address from 0.
    fill_random();
    run_frame(2, 1'b0);
    check("f4_first_addr", first_addr, 0);
    check("f4_write_count", frame_wr, FRAME);
    check("f4_done_count", frame_done, 1);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofm_writer.md
# ofm_writer

Output-side writeback engine for the convolution datapath. It accepts accumulated partial-sum results from the accumulator through a valid/ready handshake and quantizes each one: arithmetic shift, optional ReLU, saturation. It generates the output feature-map buffer address in raster order (channel, row, column) and issues one buffer write per accepted result. The input-side controller drives the feature-map and weight read addresses; this block is the matching write end.

## Interface
Parameters:
- ACC_W, 32, accumulator result width (signed)
- DATA_W, 8, stored output width (signed)
- OUT_SIZE, 28, output map height = width
- OUT_CHANNEL, 6, number of output channels
- ADDR_W, 16, output buffer address width
- SHIFT, 8, arithmetic right-shift applied before saturation
- RELU, 1, 1 = clamp negatives to 0

Ports:
- clock  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- start  in  1  one-cycle pulse; begins a frame of OUT_CHANNEL*OUT_SIZE*OUT_SIZE writes
- acc_valid  in  1  acc_data holds a finished result
- acc_data  in  ACC_W  signed accumulated result
- acc_ready  out  1  block accepts a result this cycle
- out_ena  out  1  buffer port enable
- out_wea  out  1  buffer write enable
- out_addr  out  ADDR_W  buffer write address
- out_data  out  DATA_W  quantized result
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last write of a frame

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE to RUN on start: clear counters c, r and m to 0.
  - RUN to DRAIN when the final result (m=OUT_CHANNEL-1, r=c=OUT_SIZE-1) is accepted.
  - DRAIN to IDLE once that write has issued; done pulses in the same cycle as that transition.
- acc_ready = (state==RUN). A result is accepted when acc_valid && acc_ready. acc_valid outside RUN is ignored and produces no write.
- Counters advance on each accept:
  - c increments; it wraps to 0 at OUT_SIZE-1, incrementing r.
  - r wraps to 0 at OUT_SIZE-1, incrementing m.
- Address = m*OUT_SIZE*OUT_SIZE + r*OUT_SIZE + c, computed from the pre-increment counter values.
- Quantize:
  - q = acc_data >>> SHIFT (floor, no rounding).
  - If RELU and q<0, q=0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- busy = (state != IDLE).
- start while busy is ignored.

## Timing
- Reset values: acc_ready=0, out_ena=0, out_wea=0, out_addr=0, out_data=0, busy=0, done=0. State is IDLE and all counters are 0.
- Latency is 2 cycles. A result accepted at edge t produces out_ena=out_wea=1 with its out_addr and out_data during cycle t+2, for exactly one cycle.
  - Stage 1 registers the quantized value and the address.
  - Stage 2 registers the buffer port.
- Back-to-back accepts give one write per cycle with no bubbles. The buffer port has no backpressure.
- done is asserted in the cycle after the final write's out_wea cycle. busy falls in the same cycle done rises.
- start in the same cycle as done (DRAIN to IDLE): ignored. start is valid from the following cycle.
- rst_n asserted mid-frame: the pipeline is flushed, no further write is issued, and the block returns to IDLE immediately (asynchronous).
- Address width: the product terms are computed at ADDR_W. OUT_CHANNEL*OUT_SIZE^2 must be at most 2^ADDR_W; this is checked by an elaboration-time assertion.

## Structure
- Package ofm_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the localparam FRAME_LEN = OUT_CHANNEL*OUT_SIZE*OUT_SIZE;
  - a saturation helper function.
- One sub-module, ofm_quant: purely combinational shift, ReLU and saturate, parameterized on ACC_W, DATA_W, SHIFT and RELU. It is instantiated in stage 1.
- The counters, FSM and the two pipeline stages live in ofm_writer.

## Test plan
- Quantization, default parameters:
  - acc_data=4660 gives out_data=18.
  - acc_data=40000 gives out_data=127 (saturated).
  - acc_data=-300 gives out_data=0 (RELU=1).
  - acc_data=-300 with RELU=0 gives out_data=-2 (floor of -1.17).
- Full frame with acc_valid held high:
  - exactly 4704 writes, with out_addr running 0,1,…,4703 in consecutive cycles;
  - done pulses once, the cycle after the write to 4703;
  - busy drops with done.
- Throttled input (acc_valid toggling 1,0): out_wea pattern mirrors the accepts delayed by 2 cycles, and addresses stay contiguous.
- Row/channel wrap:
  - accept #28 goes to address 28 (r=1, c=0);
  - accept #784 goes to address 784 (m=1).
- Protocol violations:
  - acc_valid=1 in IDLE gives acc_ready=0 and no write;
  - start pulsed mid-frame leaves the counters and addresses unchanged.
- Reset mid-frame: rst_n low after 100 accepts sets all outputs to reset values within the same cycle. A new start then restarts addressing at 0.
